// File: rtl/serial_out_arbiter_pkg.sv
// Shared constants and small combinational helpers for the serial output arbiter.
package serial_out_arbiter_pkg;

   // Helpers operate on a fixed 8-bit view; narrower source vectors are zero-extended.
   localparam int unsigned MaxChannels = 8;
   localparam int unsigned CollWidth   = 8;

   // Index of the lowest set bit, 0 when none is set.
   function automatic logic [2:0] lowest_idx(input logic [MaxChannels-1:0] v);
      logic [2:0] idx;
      logic       found;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < MaxChannels; i++) begin
         if (v[i] && !found) begin
            idx   = 3'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   // Number of set bits.
   function automatic logic [3:0] popcount(input logic [MaxChannels-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < MaxChannels; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/serial_out_arbiter_sat_counter.sv
// Saturating up-counter that can take several increments in one cycle.
module sat_counter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_INC = 1
) (
   input  logic                           clk_sys,
   input  logic                           reset_n,
   input  logic [$clog2(MAX_INC+1)-1:0]   inc,
   output logic [WIDTH-1:0]               count
);

   localparam logic [WIDTH:0] CountMax = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH:0]   sum;

   // Add in one extra bit of headroom, then clamp at all-ones.
   always_comb begin
      sum     = (WIDTH+1)'(count_q) + (WIDTH+1)'(inc);
      count_d = (sum > CountMax) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/serial_out_arbiter.sv
// Merges several single-bit serial sources onto one TX line with per-frame ownership,
// idle-release timeout, enable masking, collision counting and a last-change-wins legacy mode.
module serial_out_arbiter
   import serial_out_arbiter_pkg::*;
#(
   parameter int unsigned CHANNELS    = 3,
   parameter int unsigned IDLE_CYCLES = 2916,
   parameter bit          IDLE_LEVEL  = 1'b1,
   parameter bit          LEGACY      = 1'b0
) (
   input  logic                        clk_sys,
   input  logic                        reset_n,
   input  logic                        ce,
   input  logic [CHANNELS-1:0]         src_in,
   input  logic [CHANNELS-1:0]         src_en,
   output logic                        tx,
   output logic [$clog2(CHANNELS)-1:0] owner,
   output logic                        owner_valid,
   output logic [CollWidth-1:0]        collisions
);

   localparam int unsigned OwnerW = $clog2(CHANNELS);
   localparam int unsigned CntW   = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

   typedef enum logic {StIdle, StOwned} state_e;

   state_e              state_q, state_d;
   logic [CHANNELS-1:0] prev_q;
   logic [OwnerW-1:0]   owner_q, owner_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                tx_q, tx_d;
   logic [OwnerW-1:0]   coll_inc;

   logic [CHANNELS-1:0]    edges;
   logic [MaxChannels-1:0] edges_w, other_w, src_w, en_w, owner_oh_w;
   logic [2:0]             owner_ix, low_all, low_other;
   logic [3:0]             pc_all, pc_other;

   assign edges      = (src_in ^ prev_q) & src_en;
   assign edges_w    = MaxChannels'(edges);
   assign src_w      = MaxChannels'(src_in);
   assign en_w       = MaxChannels'(src_en);
   assign owner_ix   = 3'(owner_q);
   assign owner_oh_w = MaxChannels'(1) << owner_ix;
   assign other_w    = edges_w & ~owner_oh_w;
   assign low_all    = lowest_idx(edges_w);
   assign low_other  = lowest_idx(other_w);
   assign pc_all     = popcount(edges_w);
   assign pc_other   = popcount(other_w);

   // Next-state, grant and collision-increment logic.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      tx_d     = tx_q;
      coll_inc = '0;

      if (LEGACY) begin
         state_d = StIdle;
         owner_d = '0;
         cnt_d   = '0;
         if (|edges) begin
            tx_d = src_w[low_all];
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               tx_d    = IDLE_LEVEL;
               owner_d = '0;
               cnt_d   = '0;
               if (|edges) begin
                  state_d  = StOwned;
                  owner_d  = OwnerW'(low_all);
                  tx_d     = src_w[low_all];
                  coll_inc = OwnerW'(pc_all - 4'd1);
               end
            end
            StOwned: begin
               if (!en_w[owner_ix]) begin
                  // Owner masked: drop the line, but a same-cycle edge is granted as from idle.
                  state_d = StIdle;
                  owner_d = '0;
                  tx_d    = IDLE_LEVEL;
                  cnt_d   = '0;
                  if (|edges) begin
                     state_d  = StOwned;
                     owner_d  = OwnerW'(low_all);
                     tx_d     = src_w[low_all];
                     coll_inc = OwnerW'(pc_all - 4'd1);
                  end
               end else begin
                  tx_d     = src_w[owner_ix];
                  coll_inc = OwnerW'(pc_other);
                  if (edges_w[owner_ix] || (src_w[owner_ix] != IDLE_LEVEL)) begin
                     cnt_d = '0;
                  end else if (ce) begin
                     if (cnt_q == CntW'(IDLE_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (|other_w) begin
                           // Direct handover: the winner is not counted as a collision.
                           owner_d  = OwnerW'(low_other);
                           tx_d     = src_w[low_other];
                           coll_inc = OwnerW'(pc_other - 4'd1);
                        end else begin
                           state_d = StIdle;
                           owner_d = '0;
                           tx_d    = IDLE_LEVEL;
                        end
                     end else begin
                        cnt_d = cnt_q + CntW'(1);
                     end
                  end
               end
            end
            default: begin
               state_d = StIdle;
               owner_d = '0;
               tx_d    = IDLE_LEVEL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State, ownership, idle counter and edge-history registers.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q <= StIdle;
         prev_q  <= {CHANNELS{IDLE_LEVEL}};
         owner_q <= '0;
         cnt_q   <= '0;
         tx_q    <= IDLE_LEVEL;
      end else begin
         state_q <= state_d;
         prev_q  <= src_in;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
      end
   end

   sat_counter #(
      .WIDTH   (CollWidth),
      .MAX_INC (CHANNELS - 1)
   ) u_coll (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .inc     (coll_inc),
      .count   (collisions)
   );

   assign tx          = tx_q;
   assign owner       = owner_q;
   assign owner_valid = (state_q == StOwned);

endmodule
